// File: rtl/feature_window.sv
// feature_window: per-channel sliding window of the last DEPTH accepted
// samples with an exact running sum, fill tracking and input decimation.
module feature_window #(
    parameter  int DATA_W   = 37,
    parameter  int DEPTH    = 6,
    parameter  int CHANNELS = 2,
    parameter  int DECIM    = 1,
    localparam int SUM_W    = DATA_W + $clog2(DEPTH),
    localparam int FILL_W   = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            flush,
    input  logic                            data_ready,
    input  logic [CHANNELS*DATA_W-1:0]       din,
    output logic [CHANNELS*DEPTH*DATA_W-1:0] taps,
    output logic [CHANNELS*SUM_W-1:0]        win_sum,
    output logic [FILL_W-1:0]                fill,
    output logic                            data_valid,
    output logic                            push
);

    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int EXT_W = SUM_W - DATA_W;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    sample_t           tap_q  [CHANNELS][DEPTH];
    sum_t              sum_q  [CHANNELS];
    sum_t              sum_nx [CHANNELS];
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_nx;
    logic [DEC_W-1:0]  dec_q;
    logic [DEC_W-1:0]  dec_nx;
    logic              valid_q;
    logic              push_q;
    logic              run;
    logic              qual;
    logic              clear;
    logic              dec_hit;
    logic              accept;

    function automatic sum_t sext(input sample_t s);
        return {{EXT_W{s[DATA_W-1]}}, s};
    endfunction

    // en is an active-low enable: every update is gated by run.
    assign run     = ~en;
    assign qual    = run & data_ready & ~flush;
    assign clear   = run & flush;
    assign dec_hit = (dec_q == DEC_W'(DECIM - 1));
    assign accept  = qual & dec_hit;

    always_comb begin
        dec_nx = dec_q;
        if (clear) begin
            dec_nx = '0;
        end else if (qual) begin
            dec_nx = dec_hit ? '0 : dec_q + DEC_W'(1);
        end
    end

    always_comb begin
        fill_nx = fill_q;
        if (clear) begin
            fill_nx = '0;
        end else if (accept && fill_q != FILL_W'(DEPTH)) begin
            fill_nx = fill_q + FILL_W'(1);
        end
    end

    // SUM_W covers DEPTH full-scale samples, so the add/subtract stays exact.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sum_nx[c] = sum_q[c];
            if (clear) begin
                sum_nx[c] = '0;
            end else if (accept) begin
                sum_nx[c] = sum_q[c]
                          + sext(din[c*DATA_W +: DATA_W])
                          - sext(tap_q[c][DEPTH-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    tap_q[c][k] <= '0;
                end
            end
        end else if (clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    tap_q[c][k] <= '0;
                end
            end
        end else if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                tap_q[c][0] <= din[c*DATA_W +: DATA_W];
                for (int k = 1; k < DEPTH; k++) begin
                    tap_q[c][k] <= tap_q[c][k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c] <= '0;
            end
            fill_q  <= '0;
            dec_q   <= '0;
            valid_q <= 1'b0;
            push_q  <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c] <= sum_nx[c];
            end
            fill_q  <= fill_nx;
            dec_q   <= dec_nx;
            valid_q <= (fill_nx == FILL_W'(DEPTH));
            push_q  <= accept;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign win_sum[c*SUM_W +: SUM_W] = sum_q[c];
        for (genvar k = 0; k < DEPTH; k++) begin : g_tap
            assign taps[(c*DEPTH+k)*DATA_W +: DATA_W] = tap_q[c][k];
        end
    end

    assign fill       = fill_q;
    assign data_valid = valid_q;
    assign push       = push_q;

endmodule

// File: tb/tb_feature_window.sv
// Bench for feature_window: a default instance and a decimating instance
// checked against a queue-based history model plus directed scenarios.
module tb_feature_window;

    localparam int AW = 37;
    localparam int AD = 6;
    localparam int AC = 2;
    localparam int AS = 40;
    localparam int BW = 16;
    localparam int BD = 4;
    localparam int BS = 18;
    localparam int BDEC = 3;

    logic clk;
    logic rst_n;
    logic en;
    logic flush;
    logic data_ready;
    logic [AC*AW-1:0]    din_a;
    logic [AC*AD*AW-1:0] taps_a;
    logic [AC*AS-1:0]    win_sum_a;
    logic [2:0]          fill_a;
    logic                data_valid_a;
    logic                push_a;
    logic [BW-1:0]       din_b;
    logic [BD*BW-1:0]    taps_b;
    logic [BS-1:0]       win_sum_b;
    logic [2:0]          fill_b;
    logic                data_valid_b;
    logic                push_b;

    int checks;
    int errors;

    logic [AC*AW-1:0] hist_a[$];
    logic [BW-1:0]    hist_b[$];
    int dec_a;
    int dec_b;
    bit exp_push_a;
    bit exp_push_b;

    feature_window dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .data_ready(data_ready), .din(din_a), .taps(taps_a),
        .win_sum(win_sum_a), .fill(fill_a),
        .data_valid(data_valid_a), .push(push_a)
    );

    feature_window #(
        .DATA_W(BW), .DEPTH(BD), .CHANNELS(1), .DECIM(BDEC)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .data_ready(data_ready), .din(din_b), .taps(taps_b),
        .win_sum(win_sum_b), .fill(fill_b),
        .data_valid(data_valid_b), .push(push_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint tap_a(input int c, input int k);
        logic [AW-1:0] t;
        t = taps_a[(c*AD+k)*AW +: AW];
        return longint'($signed(t));
    endfunction

    function automatic longint sum_a(input int c);
        logic [AS-1:0] t;
        t = win_sum_a[c*AS +: AS];
        return longint'($signed(t));
    endfunction

    function automatic longint tap_b(input int k);
        logic [BW-1:0] t;
        t = taps_b[k*BW +: BW];
        return longint'($signed(t));
    endfunction

    function automatic longint etap_a(input int c, input int k);
        logic [AC*AW-1:0] w;
        logic [AW-1:0] t;
        if (k >= hist_a.size()) return 0;
        w = hist_a[k];
        t = w[c*AW +: AW];
        return longint'($signed(t));
    endfunction

    function automatic longint etap_b(input int k);
        logic [BW-1:0] t;
        if (k >= hist_b.size()) return 0;
        t = hist_b[k];
        return longint'($signed(t));
    endfunction

    function automatic longint esum_a(input int c);
        longint s;
        s = 0;
        for (int k = 0; k < AD; k++) s += etap_a(c, k);
        return s;
    endfunction

    function automatic longint esum_b();
        longint s;
        s = 0;
        for (int k = 0; k < BD; k++) s += etap_b(k);
        return s;
    endfunction

    function automatic int efill_a();
        return (hist_a.size() < AD) ? hist_a.size() : AD;
    endfunction

    function automatic int efill_b();
        return (hist_b.size() < BD) ? hist_b.size() : BD;
    endfunction

    function automatic logic [AC*AW-1:0] pa(input longint c0, input longint c1);
        return {c1[AW-1:0], c0[AW-1:0]};
    endfunction

    function automatic void model_reset();
        hist_a.delete();
        hist_b.delete();
        dec_a = 0;
        dec_b = 0;
        exp_push_a = 0;
        exp_push_b = 0;
    endfunction

    // Behaviour at one rising edge, from the window rules.
    function automatic void model_edge(input bit e, input bit f, input bit d,
                                       input logic [AC*AW-1:0] da,
                                       input logic [BW-1:0] db);
        exp_push_a = 0;
        exp_push_b = 0;
        if (e) return;
        if (f) begin
            model_reset();
            return;
        end
        if (!d) return;
        if (dec_a == 0) begin
            hist_a.push_front(da);
            exp_push_a = 1;
        end
        if (dec_b == BDEC - 1) begin
            hist_b.push_front(db);
            exp_push_b = 1;
        end
        dec_b = (dec_b + 1) % BDEC;
    endfunction

    task automatic check_all();
        for (int c = 0; c < AC; c++) begin
            for (int k = 0; k < AD; k++) begin
                chk($sformatf("a_tap%0d_%0d", c, k), tap_a(c, k), etap_a(c, k));
            end
            chk($sformatf("a_sum%0d", c), sum_a(c), esum_a(c));
        end
        chk("a_fill", longint'(fill_a), longint'(efill_a()));
        chk("a_valid", longint'(data_valid_a), longint'(efill_a() == AD));
        chk("a_push", longint'(push_a), longint'(exp_push_a));
        for (int k = 0; k < BD; k++) begin
            chk($sformatf("b_tap%0d", k), tap_b(k), etap_b(k));
        end
        chk("b_sum", longint'($signed(win_sum_b)), esum_b());
        chk("b_fill", longint'(fill_b), longint'(efill_b()));
        chk("b_valid", longint'(data_valid_b), longint'(efill_b() == BD));
        chk("b_push", longint'(push_b), longint'(exp_push_b));
    endtask

    task automatic step(input bit e, input bit f, input bit d,
                        input logic [AC*AW-1:0] da, input logic [BW-1:0] db);
        en = e;
        flush = f;
        data_ready = d;
        din_a = da;
        din_b = db;
        @(posedge clk);
        model_edge(e, f, d, da, db);
        #1;
        check_all();
    endtask

    initial begin
        bit re, rf, rd;
        logic [AC*AW-1:0] rda;
        logic [BW-1:0] rdb;
        longint neg;
        int npush;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        en = 1'b1;
        flush = 1'b0;
        data_ready = 1'b0;
        din_a = '0;
        din_b = '0;
        model_reset();

        #2;
        check_all();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;

        // Six pushes of +i / -i, then a seventh that slides the window.
        step(0, 1, 0, '0, '0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 1, pa(i, -i), BW'(i));
            chk("a_valid_rise", longint'(data_valid_a), longint'(i == 6));
        end
        chk("a_sum0_21", sum_a(0), 21);
        chk("a_sum1_m21", sum_a(1), -21);
        chk("a_tap0_6", tap_a(0, 0), 6);
        step(0, 0, 1, pa(10, -7), '0);
        chk("a_tap5_2", tap_a(0, 5), 2);
        chk("a_sum0_30", sum_a(0), 30);
        chk("a_fill_6", longint'(fill_a), 6);
        chk("a_valid_hold", longint'(data_valid_a), 1);

        // Decimation by three on dut_b.
        step(0, 1, 0, '0, '0);
        npush = 0;
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 1, pa(i, i), BW'(i));
            npush += int'(push_b);
        end
        chk("b_fill_3", longint'(fill_b), 3);
        chk("b_tap0_9", tap_b(0), 9);
        chk("b_tap1_6", tap_b(1), 6);
        chk("b_tap2_3", tap_b(2), 3);
        chk("b_push_cnt", longint'(npush), 3);

        // en high blocks strobe and flush; flush beats data_ready.
        step(1, 0, 1, pa(99, 99), 16'd99);
        step(1, 1, 1, pa(98, 98), 16'd98);
        chk("a_hold_fill", longint'(fill_a), 6);
        step(0, 1, 1, pa(97, 97), 16'd97);
        chk("a_flush_fill", longint'(fill_a), 0);
        chk("a_flush_sum", sum_a(0), 0);
        chk("a_flush_push", longint'(push_a), 0);

        // Full-scale negative samples must not wrap.
        neg = -(longint'(1) <<< 36);
        for (int i = 0; i < 6; i++) step(0, 0, 1, pa(neg, neg), 16'h8000);
        chk("a_negsum0", sum_a(0), neg * 6);
        chk("a_negsum1", sum_a(1), neg * 6);

        // Asynchronous reset between edges after four pushes.
        step(0, 1, 0, '0, '0);
        for (int i = 1; i <= 4; i++) step(0, 0, 1, pa(i * 3, -i), BW'(i));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("a_rst_fill", longint'(fill_a), 0);
        rst_n = 1'b1;
        step(0, 0, 1, pa(55, -55), 16'd55);
        chk("a_rst_fill1", longint'(fill_a), 1);
        chk("a_rst_tap0", tap_a(0, 0), 55);

        for (int i = 0; i < 300; i++) begin
            re = ($urandom_range(0, 7) == 0);
            rf = ($urandom_range(0, 24) == 0);
            rd = ($urandom_range(0, 2) != 0);
            rda = {$urandom(), $urandom(), $urandom()} & {(AC*AW){1'b1}};
            rdb = BW'($urandom());
            step(re, rf, rd, rda, rdb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/feature_window.md
FEATURE_WINDOW -- requirements
Module: feature_window

Interface
REQ-001 Parameter DATA_W, default 37: width of each signed sample.
REQ-002 Parameter DEPTH, default 6, legal range 2..16: number of taps per channel.
REQ-003 Parameter CHANNELS, default 2, legal range 1..8: independent channels that shift in lockstep.
REQ-004 Parameter DECIM, default 1, legal range 1..15: one sample is accepted per DECIM qualified data_ready pulses.
REQ-005 Derived constant SUM_W SHALL equal DATA_W + ceil(log2(DEPTH)).
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  active-low enable; when high, all state holds.
REQ-009 flush  input  1  synchronous clear of the window, sums, fill count and decimation counter.
REQ-010 data_ready  input  1  one-cycle strobe from the accumulator unit: din is presented.
REQ-011 din  input  CHANNELS*DATA_W  signed samples; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-012 taps  output  CHANNELS*DEPTH*DATA_W  tap k of channel c at [(c*DEPTH+k)*DATA_W +: DATA_W]; k=0 is newest.
REQ-013 win_sum  output  CHANNELS*SUM_W  signed sum of all DEPTH taps per channel.
REQ-014 fill  output  ceil(log2(DEPTH+1))  number of valid taps, saturating at DEPTH.
REQ-015 data_valid  output  1  high while fill == DEPTH.
REQ-016 push  output  1  one-cycle pulse in the cycle after a sample is accepted.

Function
REQ-017 A qualified strobe SHALL be en==0 && data_ready==1 && flush==0.
REQ-018 The decimation counter dec_cnt SHALL increment on each qualified strobe and wrap from DECIM-1 to 0.
REQ-019 A sample SHALL be accepted on a qualified strobe with dec_cnt == DECIM-1; when DECIM == 1, every qualified strobe is accepted.
REQ-020 On acceptance, tap0 SHALL load din and tap k SHALL load tap k-1 for k = 1..DEPTH-1, for every channel in the same edge.
REQ-021 On acceptance, win_sum per channel SHALL update to win_sum + din - tap(DEPTH-1), sign-extended to SUM_W, and SHALL never overflow.
REQ-022 win_sum SHALL equal the exact signed sum of the current taps at all times.
REQ-023 On acceptance, fill SHALL increment while below DEPTH and hold at DEPTH.
REQ-024 All outputs SHALL be registered; taps, win_sum, fill and data_valid reflect an accepted sample on the edge after acceptance, with push high for that cycle only.
REQ-025 If en is high, no state SHALL change, including dec_cnt; push SHALL be 0.
REQ-026 If flush == 1 and en == 0, all taps, win_sum, fill and dec_cnt SHALL clear to 0 at the next edge; flush overrides a simultaneous data_ready, and push SHALL be 0.
REQ-027 If flush == 1 and en == 1, state SHALL hold; en takes priority.
REQ-028 A data_ready held high for several cycles SHALL count as one strobe per cycle.

Reset
REQ-029 While rst_n is low, taps, win_sum, fill, dec_cnt, data_valid and push SHALL be 0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard all window contents immediately; the first accepted sample after release SHALL enter tap0 with fill = 1.
REQ-031 Release of rst_n SHALL be synchronised externally; no state SHALL change in the release cycle unless a strobe is qualified.

Verification
REQ-032 DEPTH=6, CHANNELS=2, DECIM=1: push ch0 = 1..6 and ch1 = -1..-6 -> data_valid rises after the 6th push; win_sum ch0 = 21, ch1 = -21; tap0 ch0 = 6.
REQ-033 Continue with a 7th push (ch0 = 10) -> tap5 ch0 = 2, win_sum ch0 = 30, fill stays 6, data_valid stays 1.
REQ-034 DECIM=3: nine qualified strobes with din = 1..9 -> only 3, 6 and 9 are accepted; fill = 3; push pulses three times.
REQ-035 Strobe while en = 1, then flush and data_ready together with en = 0 -> no change on the first; on the second, all outputs = 0 and push = 0.
REQ-036 DATA_W=37: push six samples of -2^36 -> win_sum = -6*2^36 exactly, with no wrap.
REQ-037 rst_n pulsed low between clock edges after 4 pushes -> outputs drop to 0 asynchronously; the next push gives fill = 1.
